// File: rtl/vga_scan_palette.sv
// VGA 640x480@60 scan generator with sprite-priority merge and fixed 8-bit palette.
// hsync/vsync/RGB are registered together and describe the pixel one tick behind hPos/vPos.
module vga_scan_palette #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int PIX_DIV   = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] hPos,
    output logic [9:0] vPos,
    input  logic [2:0] shipColor,
    input  logic [2:0] alienColor,
    input  logic [2:0] laserColor,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       frameTick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] V_VIS_M1 = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam int                DIV_W    = $clog2(PIX_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    typedef enum logic [2:0] {
        BACKGROUND = 3'd0,
        SHIP_GREEN = 3'd1,
        WHITE      = 3'd2,
        CYAN       = 3'd3,
        MAGENTA    = 3'd4,
        YELLOW     = 3'd5,
        LASER_RED  = 3'd6,
        NONE       = 3'd7
    } color_e;

    logic [DIV_W-1:0] div;
    logic             pix_tick;
    color_e           winner;
    logic             visible;
    logic [7:0]       rgb_next;

    assign pix_tick = (div == DIV_LAST);
    assign visible  = (hPos < H_VIS) && (vPos < V_VIS);

    function automatic logic transparent(input logic [2:0] code);
        return (code == BACKGROUND) || (code == NONE);
    endfunction

    always_comb begin
        winner = BACKGROUND;
        if (!transparent(laserColor))
            winner = color_e'(laserColor);
        else if (!transparent(shipColor))
            winner = color_e'(shipColor);
        else if (!transparent(alienColor))
            winner = color_e'(alienColor);
    end

    always_comb begin
        rgb_next = '0;
        if (visible) begin
            case (winner)
                SHIP_GREEN: rgb_next = {3'd0, 3'd7, 2'd0};
                WHITE:      rgb_next = {3'd7, 3'd7, 2'd3};
                CYAN:       rgb_next = {3'd0, 3'd7, 2'd3};
                MAGENTA:    rgb_next = {3'd7, 3'd0, 2'd3};
                YELLOW:     rgb_next = {3'd7, 3'd7, 2'd0};
                LASER_RED:  rgb_next = {3'd7, 3'd0, 2'd0};
                default:    rgb_next = '0;
            endcase
        end
    end

    // The delayed pixel position (hD/vD) is never stored: sync and RGB are
    // decoded from the pre-tick hPos/vPos and registered on the same tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div                 <= '0;
            hPos                <= '0;
            vPos                <= '0;
            hsync               <= 1'b1;
            vsync               <= 1'b1;
            {red, green, blue}  <= '0;
            frameTick           <= 1'b0;
        end else begin
            frameTick <= 1'b0;
            if (pix_tick) begin
                div   <= '0;
                hsync <= !((hPos >= HS_START) && (hPos < HS_END));
                vsync <= !((vPos >= VS_START) && (vPos < VS_END));
                {red, green, blue} <= rgb_next;
                frameTick <= (hPos == H_LAST) && (vPos == V_VIS_M1);
                if (hPos == H_LAST) begin
                    hPos <= '0;
                    vPos <= (vPos == V_LAST) ? '0 : vPos + 10'd1;
                end else begin
                    hPos <= hPos + 10'd1;
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_palette.sv
// Directed bench for vga_scan_palette: full-size instance for line timing,
// shrunk-timing instance for frame, priority, blanking and reset behaviour.
module tb_vga_scan_palette;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] ship, alien, laser;

    logic [9:0] h_pos, v_pos, s_h_pos, s_v_pos;
    logic       hsync, vsync, frame_tick, s_hsync, s_vsync, s_frame_tick;
    logic [2:0] red, green, s_red, s_green;
    logic [1:0] blue, s_blue;
    logic [7:0] rgb, s_rgb;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    assign rgb   = {red, green, blue};
    assign s_rgb = {s_red, s_green, s_blue};

    always #10 clk = ~clk;

    vga_scan_palette dut (
        .clk(clk), .reset(reset), .hPos(h_pos), .vPos(v_pos),
        .shipColor(ship), .alienColor(alien), .laserColor(laser),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .frameTick(frame_tick)
    );

    // 24 x 10 pixel frame at 3 clk/pixel: line = 72 clk, frame = 720 clk
    vga_scan_palette #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIX_DIV(3)
    ) dut_s (
        .clk(clk), .reset(reset), .hPos(s_h_pos), .vPos(s_v_pos),
        .shipColor(ship), .alienColor(alien), .laserColor(laser),
        .hsync(s_hsync), .vsync(s_vsync), .red(s_red), .green(s_green), .blue(s_blue),
        .frameTick(s_frame_tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the tick edge on which the small instance enters (h,v)
    task automatic wait_small(input int h, input int v, input string tag);
        bit found;
        bit prev;
        found = 1'b0;
        prev  = (s_h_pos == h) && (s_v_pos == v);
        for (int i = 0; i < 2000 && !found; i++) begin
            edge_sample();
            if ((s_h_pos == h) && (s_v_pos == v) && !prev) found = 1'b1;
            prev = (s_h_pos == h) && (s_v_pos == v);
        end
        if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic apply(input int h, input int v, input logic [2:0] l, input logic [2:0] s,
                         input logic [2:0] a, input logic [7:0] exp, input string tag);
        wait_small(h, v, tag);
        laser = l;
        ship  = s;
        alien = a;
        repeat (3) edge_sample();
        check(tag, s_rgb, exp);
    endtask

    initial begin
        int unsigned hs_low, green_cnt, black_cnt, vs_low, ft_cnt, cnt;
        logic [31:0] first_low;
        bit          have_low, prev_vs, found;
        int          ft_at[$];
        int          vs_fall[$];

        reset = 1'b0;
        ship  = 3'd0;
        alien = 3'd0;
        laser = 3'd0;
        repeat (3) edge_sample();
        check("rst_hpos", h_pos, 0);
        check("rst_vpos", v_pos, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_rgb", rgb, 0);
        check("rst_ftick", frame_tick, 0);
        check("rst_s_hpos", s_h_pos, 0);

        @(negedge clk) reset = 1'b1;
        repeat (2) edge_sample();
        check("hpos_2clk", h_pos, 1);
        check("s_hpos_2clk", s_h_pos, 0);
        edge_sample();
        check("s_hpos_3clk", s_h_pos, 1);
        repeat (1595) edge_sample();
        check("hpos_1598clk", h_pos, 799);
        check("vpos_1598clk", v_pos, 0);
        repeat (2) edge_sample();
        check("hpos_wrap", h_pos, 0);
        check("vpos_wrap", v_pos, 1);

        // One full line of the full-size instance with ship constantly green
        ship = 3'd1;
        edge_sample();
        hs_low = 0; green_cnt = 0; black_cnt = 0; have_low = 1'b0; first_low = '0;
        for (int i = 0; i < 1600; i++) begin
            edge_sample();
            if (!hsync) begin
                hs_low++;
                if (!have_low) begin
                    have_low  = 1'b1;
                    first_low = 32'(h_pos);
                end
            end
            if (rgb == 8'h1C) green_cnt++;
            if (rgb == 8'h00) black_cnt++;
        end
        check("hsync_low_clk", hs_low, 192);
        check("hsync_first_hpos", first_low, 657);
        check("line_green_clk", green_cnt, 1280);
        check("line_black_clk", black_cnt, 320);

        // Two frames of the small instance
        wait_small(0, 0, "frame_start");
        hs_low = 0; green_cnt = 0; black_cnt = 0; vs_low = 0; ft_cnt = 0;
        prev_vs = s_vsync;
        for (int i = 1; i <= 1440; i++) begin
            edge_sample();
            if (i <= 720) begin
                if (!s_hsync) hs_low++;
                if (!s_vsync) vs_low++;
                if (s_rgb == 8'h1C) green_cnt++;
                if (s_rgb == 8'h00) black_cnt++;
                if (s_frame_tick) ft_cnt++;
            end
            if (s_frame_tick) begin
                ft_at.push_back(i);
                check("ftick_vpos", s_v_pos, 6);
                check("ftick_hpos", s_h_pos, 0);
            end
            if (prev_vs && !s_vsync) vs_fall.push_back(i);
            prev_vs = s_vsync;
        end
        check("frame_hsync_low", hs_low, 90);
        check("frame_vsync_low", vs_low, 144);
        check("frame_green", green_cnt, 288);
        check("frame_black", black_cnt, 432);
        check("frame_ftick_cnt", ft_cnt, 1);
        check("ftick_total", ft_at.size(), 2);
        if (ft_at.size() == 2) begin
            check("ftick_first_at", ft_at[0], 432);
            check("ftick_period", ft_at[1] - ft_at[0], 720);
        end
        check("vsync_falls", vs_fall.size(), 2);
        if (vs_fall.size() == 2) check("vsync_period", vs_fall[1] - vs_fall[0], 720);

        // Priority, palette and blanking at chosen pixels
        apply(5, 2, 3'd6, 3'd1, 3'd2, 8'hE0, "laser_wins");
        apply(5, 2, 3'd7, 3'd1, 3'd2, 8'h1C, "ship_over_alien");
        apply(5, 2, 3'd0, 3'd0, 3'd4, 8'hE3, "alien_magenta");
        apply(5, 2, 3'd7, 3'd7, 3'd7, 8'h00, "all_none");
        apply(5, 2, 3'd0, 3'd3, 3'd5, 8'h1F, "ship_cyan");
        apply(5, 2, 3'd7, 3'd0, 3'd5, 8'hFC, "alien_yellow");
        apply(5, 2, 3'd0, 3'd7, 3'd2, 8'hFF, "alien_white");
        apply(20, 2, 3'd6, 3'd1, 3'd2, 8'h00, "hblank");
        apply(5, 7, 3'd6, 3'd1, 3'd2, 8'h00, "vblank");

        // Input glitch between ticks must not reach the output
        wait_small(5, 2, "glitch");
        laser = 3'd6;
        ship  = 3'd0;
        alien = 3'd0;
        edge_sample();
        laser = 3'd0;
        ship  = 3'd1;
        repeat (2) edge_sample();
        check("glitch_ignored", s_rgb, 8'h1C);

        // Asynchronous reset mid-frame
        wait_small(7, 3, "midreset");
        check("pre_reset_rgb", s_rgb, 8'h1C);
        #3;
        reset = 1'b0;
        #1;
        check("async_s_hpos", s_h_pos, 0);
        check("async_s_vpos", s_v_pos, 0);
        check("async_s_rgb", s_rgb, 0);
        check("async_s_vsync", s_vsync, 1);
        check("async_hpos", h_pos, 0);
        repeat (2) edge_sample();
        check("held_s_hpos", s_h_pos, 0);
        @(negedge clk) reset = 1'b1;
        found = 1'b0;
        cnt   = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            edge_sample();
            cnt++;
            if (s_frame_tick) found = 1'b1;
        end
        check("ftick_after_reset_found", found, 1);
        check("ftick_after_reset_clk", cnt, 432);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
